ofifo: RTL

OFIFO -- requirements
Module: ofifo

---
 rtl/ofifo_pkg.sv | 11 +
 rtl/ofifo_col.sv | 66 ++++++
 rtl/ofifo.sv | 96 +++++++++
 3 files changed

// File: rtl/ofifo_pkg.sv
// Output FIFO shared constants: lane count, lane width, lane depth, pointer width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ofifo_pkg;

    localparam int COL   = 8;                     // independent lanes
    localparam int BW    = 16;                    // bits per lane entry
    localparam int DEPTH = 16;                    // entries per lane, power of two
    localparam int PTR_W = $clog2(DEPTH) + 1;     // extra MSB tells full from empty

endpackage

// File: rtl/ofifo_col.sv
// One output-FIFO lane: circular buffer with its own write pointer and a read pointer stepped by the top.
// Latency: head_o is combinational from storage; a write is visible at head_o the cycle after it lands.
// Backpressure: none internally; the top decides wr_ok_i/rd_ok_i from full_o/empty_o.
//
// Ports:
//   clk_i      clock, all state on posedge
//   rst_n_i    synchronous active-low reset of both pointers
//   wr_ok_i    write accepted this cycle (already qualified by the top)
//   rd_ok_i    read accepted this cycle (same strobe for every lane)
//   wdat_i     write data
//   head_o     oldest stored entry
//   empty_o    no entries held
//   full_o     depth entries held
module ofifo_col
    import ofifo_pkg::*;
#(
    parameter int depth = DEPTH,
    parameter int bw    = BW
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          wr_ok_i,
    input  logic          rd_ok_i,
    input  logic [bw-1:0] wdat_i,
    output logic [bw-1:0] head_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int AW    = $clog2(depth);
    localparam int PTR_W_L = AW + 1;

    logic [bw-1:0]      mem_q [depth];
    logic [PTR_W_L-1:0] wptr_q, wptr_d;
    logic [PTR_W_L-1:0] rptr_q, rptr_d;

    // Power-of-two depth: the pointer simply rolls over, so depth-1 -> 0 needs no special case.
    always_comb begin
        wptr_d = wr_ok_i ? wptr_q + PTR_W_L'(1) : wptr_q;
        rptr_d = rd_ok_i ? rptr_q + PTR_W_L'(1) : rptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    // When full with a same-cycle read, the write lands in the slot being popped;
    // the pop sees the old value because both happen on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && wr_ok_i) begin
            mem_q[wptr_q[AW-1:0]] <= wdat_i;
        end
    end

    assign head_o  = mem_q[rptr_q[AW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

endmodule

// File: rtl/ofifo.sv
// Output FIFO: col independent lanes filled at their own pace, drained as one aligned word.
// Latency: accepted rd loads out on that posedge; o_out_valid is high for the following cycle only.
// Backpressure: rd ignored unless every lane holds data; writes to a full lane are dropped and flagged sticky.
//
// Ports:
//   clk          clock
//   reset        synchronous active-low reset
//   in           write data, lane c on [(c+1)*bw-1 : c*bw]
//   wr           per-lane write strobe
//   rd           pop one word from all lanes
//   out          registered popped word, same slicing as in
//   o_out_valid  out was loaded by a pop on the last edge
//   o_valid      all lanes non-empty (rd will be accepted)
//   o_full       any lane full
//   o_ready      !o_full
//   o_overflow   sticky: a write to a full lane was dropped
module ofifo
    import ofifo_pkg::*;
#(
    parameter int col   = COL,
    parameter int bw    = BW,
    parameter int depth = DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [col*bw-1:0] in,
    input  logic [col-1:0]    wr,
    input  logic              rd,
    output logic [col*bw-1:0] out,
    output logic              o_out_valid,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_ready,
    output logic              o_overflow
);

    logic [col-1:0]    empty_v;
    logic [col-1:0]    full_v;
    logic [col-1:0]    wr_ok_v;
    logic [col-1:0]    ovf_hit_v;
    logic [col*bw-1:0] head_flat;
    logic              rd_acc;

    logic [col*bw-1:0] out_q, out_d;
    logic              out_vld_q, out_vld_d;
    logic              ovf_q, ovf_d;

    // Status depends only on pointers, never on this cycle's wr/rd.
    assign o_valid = &(~empty_v);
    assign o_full  = |full_v;
    assign o_ready = ~o_full;
    assign rd_acc  = rd & o_valid;

    for (genvar g = 0; g < col; g++) begin : g_lane
        // A full lane can still take a write when the pop frees a slot on the same edge.
        assign wr_ok_v[g]   = wr[g] & (~full_v[g] | rd_acc);
        assign ovf_hit_v[g] = wr[g] & full_v[g] & ~rd_acc;

        ofifo_col #(
            .depth (depth),
            .bw    (bw)
        ) u_col (
            .clk_i   (clk),
            .rst_n_i (reset),
            .wr_ok_i (wr_ok_v[g]),
            .rd_ok_i (rd_acc),
            .wdat_i  (in[g*bw +: bw]),
            .head_o  (head_flat[g*bw +: bw]),
            .empty_o (empty_v[g]),
            .full_o  (full_v[g])
        );
    end

    always_comb begin
        out_d     = rd_acc ? head_flat : out_q;
        out_vld_d = rd_acc;
        ovf_d     = ovf_q | (|ovf_hit_v);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out         = out_q;
    assign o_out_valid = out_vld_q;
    assign o_overflow  = ovf_q;

endmodule
